// File: rtl/sd_dac_sequencer_if.sv
// Stream sample handshake between an audio sample source and the DAC sequencer.
// The sequencer is the slave: it raises s_ready only on the cycle it takes a sample.
interface sd_dac_sequencer_if;
  logic               s_valid;
  logic signed [15:0] s_data;
  logic               s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/sd_dac_sequencer.sv
// Power-up / playback sequencer for a sigma-delta DAC: waits for PLL lock, settles the
// modulator on silence, then ramps a 0..256 gain applied to the selected sample source.
module sd_dac_sequencer #(
  parameter int unsigned OSR            = 128,
  parameter int unsigned LOCK_CYCLES    = 1024,
  parameter int unsigned SETTLE_SAMPLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               run,
  input  logic               src_sel,
  input  logic signed [15:0] tone_sample,
  sd_dac_sequencer_if.slave  stream,
  output logic signed [15:0] sample_out,
  output logic               sample_stb,
  output logic               mod_reset,
  output logic               underrun,
  output logic [2:0]         state
);
  localparam int unsigned PW = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam int unsigned SW = $clog2(SETTLE_SAMPLES + 1);
  localparam logic [PW-1:0] PHASE_LAST  = PW'(OSR - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_SAMPLES - 1);
  localparam logic [8:0]    GAIN_FULL   = 9'd256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOCK_WAIT = 3'd1,
    SETTLE    = 3'd2,
    RAMP_UP   = 3'd3,
    RUN       = 3'd4,
    RAMP_DOWN = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [8:0]        gain_q, gain_d;
  logic [PW-1:0]     phase_q;
  logic [LW-1:0]     lock_cnt_q;
  logic [SW-1:0]     settle_cnt_q;
  logic              active_q, active_d, stb;
  logic signed [15:0] src;
  logic [24:0]       prod;

  assign active_q = state_q inside {SETTLE, RAMP_UP, RUN, RAMP_DOWN};
  assign active_d = state_d inside {SETTLE, RAMP_UP, RUN, RAMP_DOWN};
  assign stb      = active_q && (phase_q == PHASE_LAST);

  assign sample_stb     = stb;
  assign stream.s_ready = stb && src_sel;
  assign underrun       = stb && src_sel && !stream.s_valid;
  assign state          = state_q;

  // A missing stream sample is replaced by silence rather than stalling the strobe.
  assign src  = src_sel ? (stream.s_valid ? stream.s_data : '0) : tone_sample;
  assign prod = {{9{src[15]}}, src} * {16'd0, gain_q};

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    case (state_q)
      IDLE: if (run) state_d = LOCK_WAIT;
      LOCK_WAIT: begin
        if (!run) state_d = IDLE;
        else if (pll_locked && lock_cnt_q == LOCK_LAST) state_d = SETTLE;
      end
      SETTLE: begin
        if (!run) state_d = IDLE;
        else if (stb && settle_cnt_q == SETTLE_LAST) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (stb && gain_q != GAIN_FULL) gain_d = gain_q + 9'd1;
        if (!run) state_d = RAMP_DOWN;
        else if (gain_d == GAIN_FULL) state_d = RUN;
      end
      RUN: begin
        gain_d = GAIN_FULL;
        if (!run) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (stb && gain_q != '0) gain_d = gain_q - 9'd1;
        if (run) state_d = RAMP_UP;
        else if (stb && gain_q <= 9'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Losing lock while the modulator is live overrides every other request.
    if (active_q && !pll_locked) state_d = IDLE;
    if (state_d inside {IDLE, LOCK_WAIT, SETTLE}) gain_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      gain_q       <= '0;
      phase_q      <= '0;
      lock_cnt_q   <= '0;
      settle_cnt_q <= '0;
      sample_out   <= '0;
      mod_reset    <= 1'b1;
    end else begin
      state_q   <= state_d;
      gain_q    <= gain_d;
      mod_reset <= (state_d == IDLE) || (state_d == LOCK_WAIT);
      phase_q   <= (active_q && active_d && !stb) ? phase_q + PW'(1) : '0;
      lock_cnt_q <= (state_q == LOCK_WAIT && state_d == LOCK_WAIT && pll_locked)
                    ? lock_cnt_q + LW'(1) : '0;
      if (state_d != SETTLE)   settle_cnt_q <= '0;
      else if (stb)            settle_cnt_q <= settle_cnt_q + SW'(1);
      // Scaling uses the gain held before this strobe's ramp step.
      if (!(state_d inside {RAMP_UP, RUN, RAMP_DOWN})) sample_out <= '0;
      else if (stb)            sample_out <= 16'($signed(prod) >>> 8);
    end
  end
endmodule

// File: tb/tb_sd_dac_sequencer.sv
// Bench for sd_dac_sequencer: directed sequencing checks with literal expectations,
// then randomized traffic compared every cycle against a cycle-count based model.
module tb_sd_dac_sequencer;
  localparam int OSR_T    = 16;
  localparam int LOCK_T   = 40;
  localparam int SETTLE_T = 4;

  logic clk = 1'b0;
  logic reset, pll_locked, run, src_sel;
  logic signed [15:0] tone;
  logic [15:0] sample_out;
  logic sample_stb, mod_reset, underrun;
  logic [2:0] state;

  sd_dac_sequencer_if sif ();

  sd_dac_sequencer #(.OSR(OSR_T), .LOCK_CYCLES(LOCK_T), .SETTLE_SAMPLES(SETTLE_T)) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .run(run), .src_sel(src_sel),
    .tone_sample(tone), .stream(sif), .sample_out(sample_out), .sample_stb(sample_stb),
    .mod_reset(mod_reset), .underrun(underrun), .state(state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: phase derived from cycles elapsed since SETTLE entry.
  int m_st, m_g, m_lock, m_settles, m_cyc, m_act, m_ns, m_ng, m_src;
  logic [15:0] m_out;
  bit m_ok = 1'b0;
  bit m_b, cmp_b;

  function automatic bit m_stb();
    return (m_st >= 2 && m_st <= 5) && (((m_cyc - m_act) % OSR_T) == OSR_T - 1);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_st = 0; m_g = 0; m_lock = 0; m_settles = 0; m_out = '0; m_ok = 1'b1;
    end else begin
      m_b   = m_stb();
      m_src = !src_sel ? int'(tone) : (sif.s_valid ? int'(sif.s_data) : 0);
      m_ns  = m_st;
      m_ng  = m_g;
      case (m_st)
        0: if (run) m_ns = 1;
        1: if (!run) m_ns = 0; else if (pll_locked && m_lock + 1 >= LOCK_T) m_ns = 2;
        2: if (!run) m_ns = 0; else if (m_b && m_settles + 1 >= SETTLE_T) m_ns = 3;
        3: begin
          if (m_b && m_g < 256) m_ng = m_g + 1;
          if (!run) m_ns = 5; else if (m_ng == 256) m_ns = 4;
        end
        4: begin m_ng = 256; if (!run) m_ns = 5; end
        5: begin
          if (m_b && m_g > 0) m_ng = m_g - 1;
          if (run) m_ns = 3; else if (m_b && m_g <= 1) m_ns = 0;
        end
        default: m_ns = 0;
      endcase
      if (m_st >= 2 && !pll_locked) m_ns = 0;
      if (m_ns <= 2) m_ng = 0;
      m_lock = (m_st == 1 && m_ns == 1 && pll_locked) ? m_lock + 1 : 0;
      if (m_ns != 2) m_settles = 0; else if (m_b) m_settles = m_settles + 1;
      if (m_ns <= 2) m_out = '0;
      else if (m_b) m_out = 16'((m_src * m_g) >>> 8);
      m_cyc = m_cyc + 1;
      if (m_ns == 2 && m_st != 2) m_act = m_cyc;
      m_st = m_ns;
      m_g  = m_ng;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      cmp_b = m_stb();
      chk("m_state", int'(state), m_st);
      chk("m_mod_reset", int'(mod_reset), int'(m_st <= 1));
      chk("m_sample_out", int'(sample_out), int'(m_out));
      chk("m_sample_stb", int'(sample_stb), int'(cmp_b));
      chk("m_s_ready", int'(sif.s_ready), int'(cmp_b && src_sel));
      chk("m_underrun", int'(underrun), int'(cmp_b && src_sel && !sif.s_valid));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int limit, output int n);
    n = 0;
    while (int'(state) != s && n < limit) begin tick(); n++; end
    chk("reach_state", int'(state), s);
  endtask

  task automatic wait_stb(input int limit);
    int n = 0;
    while (!sample_stb && n < limit) begin tick(); n++; end
    chk("stb_wait", int'(sample_stb), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, strobes, k, rs, ds;
    reset = 1'b1; run = 1'b0; pll_locked = 1'b1; src_sel = 1'b0; tone = 16'sh4000;
    sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (3) tick();
    chk("reset_state", int'(state), 0);
    chk("reset_mod_reset", int'(mod_reset), 1);
    chk("reset_sample_out", int'(sample_out), 0);
    chk("reset_stb", int'(sample_stb), 0);
    chk("reset_s_ready", int'(sif.s_ready), 0);
    chk("reset_underrun", int'(underrun), 0);

    reset = 1'b0; run = 1'b1;
    tick();
    chk("idle_to_lock_wait", int'(state), 1);
    wait_state(2, 500, n);
    chk("lock_cycles", n, LOCK_T);

    first = -1; strobes = 0; k = 0;
    while (int'(state) != 4 && k < 20000) begin
      if (sample_stb) begin
        if (first < 0) first = k;
        strobes++;
      end
      tick(); k++;
    end
    chk("first_strobe_offset", first, OSR_T - 1);
    chk("strobes_to_run", strobes, SETTLE_T + 256);
    chk("in_run", int'(state), 4);

    tone = 16'sh7FFF; wait_stb(100); tick();
    chk("run_tone_max", int'(sample_out), 'h7FFF);
    tone = 16'sh8000; wait_stb(100); tick();
    chk("run_tone_min", int'(sample_out), 'h8000);

    src_sel = 1'b1; sif.s_valid = 1'b0; wait_stb(100);
    chk("underrun_pulse", int'(underrun), 1);
    chk("underrun_s_ready", int'(sif.s_ready), 1);
    tick();
    chk("underrun_zero_out", int'(sample_out), 0);
    sif.s_valid = 1'b1; sif.s_data = 16'sh1234; wait_stb(100);
    chk("stream_s_ready", int'(sif.s_ready), 1);
    chk("stream_no_underrun", int'(underrun), 0);
    tick();
    chk("stream_data", int'(sample_out), 'h1234);
    src_sel = 1'b0; sif.s_valid = 1'b0; tone = 16'sh4000;

    pll_locked = 1'b0; tick();
    chk("unlock_idle", int'(state), 0);
    chk("unlock_mod_reset", int'(mod_reset), 1);
    chk("unlock_out_zero", int'(sample_out), 0);
    pll_locked = 1'b1; tick();
    chk("relock_lock_wait", int'(state), 1);
    repeat (30) tick();
    chk("still_lock_wait", int'(state), 1);
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_state(2, 500, n);
    chk("lock_after_glitch", n, LOCK_T);

    rs = 0; k = 0;
    while (rs < 128 && k < 20000) begin
      if (int'(state) == 3 && sample_stb) rs++;
      tick(); k++;
    end
    chk("ramp_gain127_out", int'(sample_out), 'h1FC0);
    run = 1'b0; tick();
    chk("ramp_down_entry", int'(state), 5);
    ds = 0; k = 0;
    while (int'(state) != 0 && k < 20000) begin
      if (sample_stb) begin
        ds++; tick();
        if (ds == 1) chk("ramp_down_gain128", int'(sample_out), 'h2000);
        if (ds == 2) chk("ramp_down_gain127", int'(sample_out), 'h1FC0);
      end else tick();
      k++;
    end
    chk("ramp_down_strobes", ds, 128);
    chk("ramp_down_out_zero", int'(sample_out), 0);

    run = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 2999) == 0) run = ~run;
      if ($urandom_range(0, 3999) == 0) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 19) == 0) pll_locked = 1'b1;
      reset = ($urandom_range(0, 9999) == 0);
      src_sel = 1'($urandom_range(0, 1));
      sif.s_valid = ($urandom_range(0, 3) != 0);
      sif.s_data = 16'($urandom);
      tone = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sd_dac_sequencer.md
SD_DAC_SEQUENCER -- requirements
Module: sd_dac_sequencer

Interface
REQ-001 Parameter OSR, default 128, clk cycles per audio sample (5.6448 MHz / 44.1 kHz).
REQ-002 Parameter LOCK_CYCLES, default 1024, consecutive cycles pll_locked must be high before release.
REQ-003 Parameter SETTLE_SAMPLES, default 16, zero-valued samples issued after modulator release.
REQ-004 clk  in  1  single clock (PLL CLK0 domain); all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pll_locked  in  1  PLL lock status.
REQ-007 run  in  1  playback request level.
REQ-008 src_sel  in  1  0 = internal tone, 1 = sample stream.
REQ-009 tone_sample  in  16  signed internal tone sample.
REQ-010 s_valid / s_data  in  1 / 16  stream sample handshake, signed data.
REQ-011 s_ready  out  1  stream sample accepted this cycle.
REQ-012 sample_out  out  16  signed scaled sample to interpolating filter.
REQ-013 sample_stb  out  1  one-cycle audio sample strobe.
REQ-014 mod_reset  out  1  active-high hold for filter and modulator.
REQ-015 underrun  out  1  one-cycle pulse: stream sample missing at strobe.
REQ-016 state  out  3  current state encoding.

Function
REQ-017 States (encoding): IDLE=0, LOCK_WAIT=1, SETTLE=2, RAMP_UP=3, RUN=4, RAMP_DOWN=5; others SHALL go to IDLE.
REQ-018 IDLE: mod_reset=1, gain=0, phase=0; run=1 -> LOCK_WAIT.
REQ-019 LOCK_WAIT: mod_reset=1; lock counter increments while pll_locked=1, clears when 0; reaching LOCK_CYCLES -> SETTLE; run=0 -> IDLE.
REQ-020 Phase counter: 0..OSR-1, wraps, runs only in SETTLE..RAMP_DOWN, starts at 0 on SETTLE entry; sample_stb=1 exactly when phase==OSR-1.
REQ-021 SETTLE: mod_reset=0, gain=0; after SETTLE_SAMPLES strobes -> RAMP_UP.
REQ-022 Gain: 9-bit unsigned 0..256; RAMP_UP +1 per strobe, at 256 -> RUN; RAMP_DOWN -1 per strobe, at 0 -> IDLE.
REQ-023 RUN: gain=256; run=0 -> RAMP_DOWN.
REQ-024 run=0 during SETTLE -> IDLE; during RAMP_UP -> RAMP_DOWN from current gain; run=1 during RAMP_DOWN -> RAMP_UP from current gain.
REQ-025 pll_locked=0 in any state except IDLE/LOCK_WAIT -> IDLE next cycle (gain 0, mod_reset 1, sample_out 0); overrides run.
REQ-026 Source: src_sel sampled only on strobe cycles; source sample = tone_sample or s_data.
REQ-027 s_ready=1 only on strobe cycles with src_sel=1 in SETTLE..RAMP_DOWN; transfer when s_valid&s_ready.
REQ-028 Strobe with src_sel=1 and s_valid=0: source sample = 0, underrun=1 for that cycle.
REQ-029 Scaling: sample_out = (source * gain) >>> 8, 25-bit signed product, arithmetic shift, truncation to 16 bits; gain=256 exact pass-through.
REQ-030 sample_out registers on strobe edge using gain before that edge's update; valid one cycle after sample_stb, held OSR cycles.
REQ-031 sample_out forced to 0 in IDLE, LOCK_WAIT and SETTLE.

Reset
REQ-032 On reset: state=IDLE, mod_reset=1, sample_out=0, sample_stb=0, s_ready=0, underrun=0, gain=0, phase=0, lock counter=0.
REQ-033 Reset mid-ramp or mid-RUN SHALL take effect next edge with no further strobes.

Verification
REQ-034 run=1, pll_locked=1 steady -> SETTLE after 1024 cycles, first sample_stb 128 cycles later, RUN after 16+256 strobes.
REQ-035 RUN, src_sel=0, tone_sample=0x7FFF -> sample_out=0x7FFF; tone_sample=0x8000 -> 0x8000.
REQ-036 RAMP_UP gain=128, tone=0x4000 -> sample_out=0x2000; run=0 -> RAMP_DOWN, gain 127 next strobe, IDLE 128 strobes later.
REQ-037 RUN, src_sel=1, s_valid=0 at strobe -> underrun pulse, s_ready=1, sample_out=0 for that sample.
REQ-038 pll_locked drops in RUN -> IDLE, mod_reset=1, sample_out=0 next cycle; relock with run=1 restarts LOCK_WAIT count from 0.
REQ-039 pll_locked glitch low after 1000 cycles in LOCK_WAIT -> counter clears, SETTLE only after further 1024 clean cycles.
